// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   MM:SS.cc BCD countdown timer with a load/run/pause/expire control FSM.
//   A prescaler divides clk down to one centisecond tick every CLOCK_COUNT+1
//   cycles while running; each tick decrements the six-digit BCD count.
//
// Ports
//   clk               system clock, all state changes on its rising edge
//   reset_n           asynchronous active-low reset
//   load              one-cycle pulse: latch (clamped) preset, go to PAUSED
//   start_stop        one-cycle pulse: toggle run/pause, acknowledge alarm
//   preset_*          BCD preset digits for MM:SS
//   tens_min..ones_ms current BCD count MM:SS.cc
//   running           high while counting down
//   alarm             high while expired
//   expired_pulse     one-cycle strobe on entry to the expired state
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int CLOCK_COUNT = 1999999
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] preset_tens_min,
    input  logic [3:0] preset_ones_min,
    input  logic [3:0] preset_tens_sec,
    input  logic [3:0] preset_ones_sec,
    output logic [3:0] tens_min,
    output logic [3:0] ones_min,
    output logic [3:0] tens_sec,
    output logic [3:0] ones_sec,
    output logic [3:0] tens_ms,
    output logic [3:0] ones_ms,
    output logic       running,
    output logic       alarm,
    output logic       expired_pulse
);

    localparam int PW = (CLOCK_COUNT > 0) ? $clog2(CLOCK_COUNT + 1) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(CLOCK_COUNT);

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      tm_q, om_q, ts_q, os_q, tc_q, oc_q;
    logic [3:0]      tm_d, om_d, ts_d, os_d, tc_d, oc_d;
    logic            pulse_q, pulse_d;

    // Decremented digits and the borrow chain feeding them.
    logic [3:0]      tm_dec, om_dec, ts_dec, os_dec, tc_dec, oc_dec;
    logic            b_oc, b_tc, b_os, b_ts, b_om;
    logic            tick;
    logic            count_zero;
    logic            count_one;

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    always_comb begin
        b_oc   = (oc_q == 4'd0);
        oc_dec = b_oc ? 4'd9 : oc_q - 4'd1;
        b_tc   = b_oc && (tc_q == 4'd0);
        tc_dec = b_oc ? ((tc_q == 4'd0) ? 4'd9 : tc_q - 4'd1) : tc_q;
        b_os   = b_tc && (os_q == 4'd0);
        os_dec = b_tc ? ((os_q == 4'd0) ? 4'd9 : os_q - 4'd1) : os_q;
        b_ts   = b_os && (ts_q == 4'd0);
        ts_dec = b_os ? ((ts_q == 4'd0) ? 4'd5 : ts_q - 4'd1) : ts_q;
        b_om   = b_ts && (om_q == 4'd0);
        om_dec = b_ts ? ((om_q == 4'd0) ? 4'd9 : om_q - 4'd1) : om_q;
        // tens_min never wraps: a nonzero count always absorbs the borrow
        // earlier, and expiry stops the count at zero.
        tm_dec = (b_om && (tm_q != 4'd0)) ? tm_q - 4'd1 : tm_q;
    end

    assign count_zero = (tm_q == 4'd0) && (om_q == 4'd0) && (ts_q == 4'd0) &&
                        (os_q == 4'd0) && (tc_q == 4'd0) && (oc_q == 4'd0);
    assign count_one  = (tm_q == 4'd0) && (om_q == 4'd0) && (ts_q == 4'd0) &&
                        (os_q == 4'd0) && (tc_q == 4'd0) && (oc_q == 4'd1);
    assign tick       = (state_q == ST_RUN) && (presc_q == PRESC_TERM);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tm_d    = tm_q;
        om_d    = om_q;
        ts_d    = ts_q;
        os_d    = os_q;
        tc_d    = tc_q;
        oc_d    = oc_q;
        pulse_d = 1'b0;

        if (load) begin
            // load dominates start_stop in every state
            tm_d    = clamp(preset_tens_min, 4'd5);
            om_d    = clamp(preset_ones_min, 4'd9);
            ts_d    = clamp(preset_tens_sec, 4'd5);
            os_d    = clamp(preset_ones_sec, 4'd9);
            tc_d    = 4'd0;
            oc_d    = 4'd0;
            presc_d = '0;
            state_d = ST_PAUSED;
        end else begin
            unique case (state_q)
                ST_PAUSED: begin
                    // prescaler keeps its phase so a resume finishes the partial tick
                    if (start_stop && !count_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        tm_d    = tm_dec;
                        om_d    = om_dec;
                        ts_d    = ts_dec;
                        os_d    = os_dec;
                        tc_d    = tc_dec;
                        oc_d    = oc_dec;
                        if (count_one) begin
                            state_d = ST_EXPIRED;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    if (start_stop) begin
                        state_d = ST_PAUSED;
                    end
                end
                default: begin
                    state_d = ST_PAUSED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PAUSED;
            presc_q <= '0;
            tm_q    <= 4'd0;
            om_q    <= 4'd0;
            ts_q    <= 4'd0;
            os_q    <= 4'd0;
            tc_q    <= 4'd0;
            oc_q    <= 4'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tm_q    <= tm_d;
            om_q    <= om_d;
            ts_q    <= ts_d;
            os_q    <= os_d;
            tc_q    <= tc_d;
            oc_q    <= oc_d;
            pulse_q <= pulse_d;
        end
    end

    assign tens_min      = tm_q;
    assign ones_min      = om_q;
    assign tens_sec      = ts_q;
    assign ones_sec      = os_q;
    assign tens_ms       = tc_q;
    assign ones_ms       = oc_q;
    assign running       = (state_q == ST_RUN);
    assign alarm         = (state_q == ST_EXPIRED);
    assign expired_pulse = pulse_q;

endmodule
